// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: maps Control_Car speed/steer/enable to ramped, glitch-free
// PWM and direction for the left and right wheel motors.
module pwm_chan #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             load,
  input  logic [PWM_W-1:0] cnt,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm
);
  logic [PWM_W-1:0] duty_sh;

  // Shadow only moves at the period boundary so a pulse is never cut short.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (load) duty_sh <= duty;
      pwm <= en && (cnt < duty_sh);
    end
  end
endmodule

module motor_pwm_driver #(
  parameter int PWM_W     = 8,
  parameter int RAMP_DIV  = 16,
  parameter int RAMP_STEP = 8,
  parameter int DUTY_SLOW = 64,
  parameter int DUTY_MED  = 128,
  parameter int DUTY_HIGH = 224,
  parameter int DUTY_REV  = 96
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       speed,
  input  logic [1:0]       steer,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             dir_l,
  output logic             dir_r,
  output logic             moving,
  output logic [PWM_W-1:0] duty_cur
);
  localparam int NUM_CH = 2;
  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

  typedef enum logic [1:0] {STOP, FWD, REV, DECEL} state_t;

  state_t                         state;
  logic                           dir;
  logic                           fwd_req, rev_req, tick, load;
  logic [PWM_W-1:0]               tgt, eff, gap, duty_nxt, cnt;
  logic [PRE_W-1:0]               pre;
  logic [NUM_CH-1:0][PWM_W-1:0]   sh_in;
  logic [NUM_CH-1:0]              pwm;

  always_comb begin
    fwd_req = 1'b0;
    rev_req = 1'b0;
    tgt     = '0;
    if (en) begin
      case (speed)
        3'd1: begin fwd_req = 1'b1; tgt = PWM_W'(DUTY_SLOW); end
        3'd2: begin fwd_req = 1'b1; tgt = PWM_W'(DUTY_MED);  end
        3'd3: begin fwd_req = 1'b1; tgt = PWM_W'(DUTY_HIGH); end
        3'd4: begin rev_req = 1'b1; tgt = PWM_W'(DUTY_REV);  end
        default: ;
      endcase
    end
  end

  // Only a matching request in the running direction holds duty up; all else drains.
  always_comb begin
    eff = '0;
    case (state)
      FWD:     if (fwd_req) eff = tgt;
      REV:     if (rev_req) eff = tgt;
      default: ;
    endcase
  end

  always_comb begin
    gap      = '0;
    duty_nxt = duty_cur;
    if (eff > duty_cur) begin
      gap      = eff - duty_cur;
      duty_nxt = (gap > STEP) ? duty_cur + STEP : eff;
    end else begin
      gap      = duty_cur - eff;
      duty_nxt = (gap > STEP) ? duty_cur - STEP : eff;
    end
  end

  assign tick = (pre == PRE_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre      <= '0;
      duty_cur <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) duty_cur <= duty_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= STOP;
      dir    <= 1'b1;
      moving <= 1'b0;
    end else begin
      case (state)
        STOP:
          if (fwd_req) begin
            state <= FWD; dir <= 1'b1; moving <= 1'b1;
          end else if (rev_req) begin
            state <= REV; dir <= 1'b0; moving <= 1'b1;
          end
        FWD:
          if (rev_req) state <= DECEL;
          else if (!fwd_req && duty_cur == '0) begin state <= STOP; moving <= 1'b0; end
        REV:
          if (fwd_req) state <= DECEL;
          else if (!rev_req && duty_cur == '0) begin state <= STOP; moving <= 1'b0; end
        DECEL:
          if (duty_cur == '0) begin state <= STOP; moving <= 1'b0; end
        default: begin state <= STOP; moving <= 1'b0; end
      endcase
    end
  end

  assign dir_l = dir;
  assign dir_r = dir;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  assign load = &cnt;

  // Channel 0 is left, channel 1 is right; the inside wheel runs at half duty.
  always_comb begin
    sh_in[0] = duty_cur;
    sh_in[1] = duty_cur;
    if (steer == 2'd1)      sh_in[1] = duty_cur >> 1;
    else if (steer == 2'd2) sh_in[0] = duty_cur >> 1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_chan #(.PWM_W(PWM_W)) u_ch (
      .clk   (clk),
      .clr_n (clr_n),
      .en    (en),
      .load  (load),
      .cnt   (cnt),
      .duty  (sh_in[c]),
      .pwm   (pwm[c])
    );
  end

  assign pwm_l = pwm[0];
  assign pwm_r = pwm[1];
endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Downstream stage of Control_Car. Consumes the speed code (M1), steering code (M2) and enable (E) that Control_Car produces, and turns them into PWM drive and direction signals for the left and right wheel motors. Duty changes are ramped so the motors never step abruptly. A drain-to-zero rule guarantees direction never flips while a motor is driven.

Parameters:
PWM_W, 8, PWM counter and duty width; PWM period is 2^PWM_W cycles.
RAMP_DIV, 16, clk cycles per ramp tick.
RAMP_STEP, 8, maximum duty change per ramp tick.
DUTY_SLOW, 64, target duty for speed code slow.
DUTY_MED, 128, target duty for speed code med.
DUTY_HIGH, 224, target duty for speed code high.
DUTY_REV, 96, target duty for speed code rev.

Ports:
clk  input  1  system clock, rising-edge.
clr_n  input  1  asynchronous active-low reset.
en  input  1  drive enable, from Control_Car E.
speed  input  3  speed code, from M1: 0 stop, 1 slow, 2 med, 3 high, 4 rev.
steer  input  2  steering code, from M2: 0 straight, 1 right, 2 left.
pwm_l  output  1  left motor PWM.
pwm_r  output  1  right motor PWM.
dir_l  output  1  left direction, 1 = forward.
dir_r  output  1  right direction, 1 = forward.
moving  output  1  high when the FSM is not in STOP.
duty_cur  output  PWM_W  current ramped duty magnitude.

Behaviour:
- Reset (clr_n low, async):
  - pwm_l = pwm_r = 0, moving = 0, duty_cur = 0, dir_l = dir_r = 1.
  - FSM to STOP; PWM counter, prescaler and shadow duties to 0.
- Target selection:
  - speed 1/2/3 gives DUTY_SLOW/MED/HIGH, forward.
  - speed 4 gives DUTY_REV, reverse.
  - speed 0, speed 5-7, or en = 0 give target 0.
- Ramp:
  - Prescaler counts 0..RAMP_DIV-1; a tick occurs on wrap.
  - On a tick, duty_cur moves toward the effective target by min(RAMP_STEP, |diff|). No overshoot; duty_cur holds when equal.
- FSM states: STOP, FWD, REV, DECEL.
  - STOP: duty_cur = 0, effective target 0. Forward request: set dir = 1, go FWD next cycle. Reverse request: set dir = 0, go REV.
  - FWD: effective target is the forward target. Request is stop or en = 0: ramp toward 0, go STOP when duty_cur = 0. Reverse request: go DECEL.
  - REV: mirror image of FWD.
  - DECEL: effective target forced to 0 regardless of request. When duty_cur = 0, go STOP. Direction is therefore re-evaluated only from STOP, at least one cycle after duty reaches 0.
  - dir changes only on the STOP-to-FWD or STOP-to-REV transition; dir_l = dir_r = dir.
- PWM generation:
  - Counter cnt is free-running 0..2^PWM_W-1, wrapping.
  - Shadow duties duty_l_sh and duty_r_sh load only on the cycle cnt = 2^PWM_W-1, so they apply from cnt = 0. This keeps pulses glitch-free.
  - Straight (steer 0 or 3): both shadows = duty_cur.
  - Right (steer 1): right shadow = duty_cur >> 1, left shadow = duty_cur.
  - Left (steer 2): the reverse.
  - pwm_x is registered high when cnt < duty_x_sh. Duty 0 gives constantly low; duty 255 gives 255 high cycles of 256.
- en = 0:
  - pwm_l and pwm_r are forced 0 on the next clk edge, independent of shadows.
  - The ramp still decays duty_cur to 0 and the FSM returns to STOP.
- Simultaneous events: a speed or steer change during a period takes effect only at the next shadow load. A ramp tick coinciding with a shadow load uses the pre-tick duty_cur.
- Reset mid-operation: all outputs return immediately to their reset values. No drain is required on reset.

Test Plan:
1. Hold clr_n low, toggle clk -> pwm_l/pwm_r/moving/duty_cur = 0, dir_l = dir_r = 1. Deassert clr_n -> stays STOP.
2. en = 1, speed = 1, steer = 0 -> duty_cur reaches 64 after 8 ticks (128 cycles), moving = 1. After the next period boundary, pwm_l and pwm_r are each high 64 of 256 cycles.
3. At duty 224 (speed 3), set speed = 0 -> duty_cur falls by 8 per tick, reaching 0 after 28 ticks (448 cycles). moving drops to 0, dir stays 1.
4. At speed 2 (duty 128), set speed = 4 -> dir stays 1 while duty ramps 128 to 0 (16 ticks). Then STOP for at least 1 cycle, dir_l = dir_r = 0, and duty ramps to 96.
5. At speed 2 steady, set steer = 1 -> from the next period, pwm_r high 64/256 and pwm_l high 128/256. steer = 2 swaps them; steer = 3 behaves as straight.
6. Mid-ramp at duty 40, set en = 0 -> pwm outputs are 0 from the next edge and duty_cur decays to 0. Separately, pulse clr_n low mid-pulse -> pwm_l is 0 immediately, without waiting for a clock edge.
